// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone register slave: FSM state encoding,
// access-counter width and a saturating increment helper.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } wb_state_e;

  localparam int CNT_WIDTH = 16;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    return (value == '1) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/wb_reg_slave_if.sv
// Point-to-point Wishbone classic bus between the test master and the register slave.
interface wb_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_slave_regfile.sv
// DEPTH x DATA_WIDTH register array with one write port, one registered read
// port and an asynchronous active-low clear of every word.
module wb_slave_regfile
  import wb_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [IDX_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // rd_data only moves on a read, so it holds its last value between acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data <= rd_zero ? '0 : mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone classic register slave: FSM with configurable wait states, address
// window decode, saturating access counters and a sticky out-of-range flag.
module wb_reg_slave
  import wb_pkg::*;
#(
  parameter int BASE_ADDRESS = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int WAIT_STATES  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_reg_slave_if.slave        bus,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] rd_count
);

  localparam int                    IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(DEPTH);
  localparam logic [3:0]            WS_LOAD   = 4'(WAIT_STATES);

  wb_state_e             state_reg, state_next;
  logic [3:0]            wcnt_reg, wcnt_next;
  logic [ADDR_WIDTH-1:0] adr_reg;
  logic                  we_reg;
  logic [DATA_WIDTH-1:0] dat_reg;
  logic                  err_reg;
  logic [CNT_WIDTH-1:0]  wr_count_reg, rd_count_reg;

  logic                  req;
  logic [ADDR_WIDTH-1:0] sel_adr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic                  go_ack;

  assign req = bus.cyc_i & bus.stb_i;

  // With zero wait states the ack edge is the capture edge, so decode must
  // look at the live bus in IDLE and at the captured request afterwards.
  always_comb begin
    sel_adr = adr_reg;
    sel_we  = we_reg;
    sel_dat = dat_reg;
    if (state_reg == IDLE) begin
      sel_adr = bus.adr_i;
      sel_we  = bus.we_i;
      sel_dat = bus.dat_i;
    end
  end

  assign offset   = sel_adr - BASE;
  assign in_range = (sel_adr >= BASE) && (offset < SPAN);

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_next = ACK;
          end else begin
            state_next = WAIT;
            wcnt_next  = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (!bus.cyc_i) begin
          state_next = IDLE;
        end else if (wcnt_reg == 4'd1) begin
          if (req) begin
            state_next = ACK;
          end
        end else begin
          wcnt_next = wcnt_reg - 4'd1;
        end
      end
      ACK:  state_next = HOLD;
      HOLD: begin
        if (!req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Writes, reads and counters all take effect on the edge that raises ack_o.
  assign go_ack = (state_next == ACK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wcnt_reg     <= '0;
      adr_reg      <= '0;
      we_reg       <= 1'b0;
      dat_reg      <= '0;
      err_reg      <= 1'b0;
      wr_count_reg <= '0;
      rd_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      if (state_reg == IDLE && req) begin
        adr_reg <= bus.adr_i;
        we_reg  <= bus.we_i;
        dat_reg <= bus.dat_i;
      end
      if (go_ack) begin
        if (!in_range) begin
          err_reg <= 1'b1;
        end
        if (sel_we) begin
          wr_count_reg <= sat_inc(wr_count_reg);
        end else begin
          rd_count_reg <= sat_inc(rd_count_reg);
        end
      end
    end
  end

  wb_slave_regfile #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (go_ack & sel_we & in_range),
    .wr_addr (offset[IDX_WIDTH-1:0]),
    .wr_data (sel_dat),
    .rd_en   (go_ack & ~sel_we),
    .rd_zero (~in_range),
    .rd_addr (offset[IDX_WIDTH-1:0]),
    .rd_data (bus.dat_o)
  );

  assign bus.ack_o = (state_reg == ACK);
  assign bus.err_o = err_reg;
  assign wr_count  = wr_count_reg;
  assign rd_count  = rd_count_reg;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Randomized scoreboard bench for wb_reg_slave: a driver issues Wishbone
// cycles and queues expected responses, a monitor checks every ack.
module tb_wb_reg_slave;
  localparam int BASE = 16;
  localparam int DEPTH = 16;
  localparam int WS = 3;

  typedef struct {
    bit          is_read;
    logic [31:0] adr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_count, rd_count;

  wb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wb_reg_slave #(
    .BASE_ADDRESS (BASE),
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .DEPTH        (DEPTH),
    .WAIT_STATES  (WS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of words plus expected flag and counters.
  logic [31:0] model_mem [DEPTH];
  logic        exp_err;
  int          exp_wr, exp_rd;
  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= 32'(BASE)) && (a - 32'(BASE) < 32'(DEPTH));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    exp_err = 1'b0;
    exp_wr  = 0;
    exp_rd  = 0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_read) check("read_data", bus.dat_o, mon_e.data);
        check("err_at_ack", 32'(bus.err_o), 32'(mon_e.err));
      end
    end
  end

  task automatic drop_req();
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
  endtask

  task automatic access(input bit we, input logic [31:0] adr, input logic [31:0] dat, input int hold);
    exp_t e;
    int   k;
    e.is_read = !we;
    e.adr     = adr;
    e.data    = '0;
    if (in_window(adr)) begin
      if (we) model_mem[int'(adr) - BASE] = dat;
      else    e.data = model_mem[int'(adr) - BASE];
    end else begin
      exp_err = 1'b1;
    end
    e.err = exp_err;
    if (we) exp_wr++; else exp_rd++;
    sb.push_back(e);
    $display("txn %s adr=%h dat=%h hold=%0d", we ? "WR" : "RD", adr, we ? dat : e.data, hold);
    @(negedge clk);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.dat_i = dat;
    @(posedge clk);
    k = 0;
    while (1) begin
      #1;
      if (bus.ack_o === 1'b1) break;
      // Request fields must be ignored once captured.
      bus.we_i  = 1'($urandom_range(0, 1));
      bus.adr_i = $urandom;
      bus.dat_i = $urandom;
      k++;
      if (k > 40) begin
        check("ack_timeout", 32'd0, 32'd1);
        drop_req();
        return;
      end
      @(posedge clk);
    end
    check("ack_latency", 32'(k), 32'(WS));
    repeat (hold) @(posedge clk);
    if (hold > 0) #1;
    drop_req();
    repeat ((hold == 0) ? 2 : 1) @(posedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_wr_count"}, 32'(wr_count), 32'(exp_wr));
    check({tag, "_rd_count"}, 32'(rd_count), 32'(exp_rd));
    check({tag, "_err"}, 32'(bus.err_o), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b0;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = '0;
    bus.dat_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_dat", bus.dat_o, 32'd0);
    check_status("rst");
    @(negedge clk) rst = 1'b1;

    // Abort: cyc_i drops two cycles into the wait; stb_i alone must be ignored.
    $display("txn ABORT adr=%h", 32'(BASE + 1));
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 32'(BASE + 1); bus.dat_i = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) bus.cyc_i = 1'b0;
    repeat (8) @(posedge clk);
    #1 bus.stb_i = 1'b0;
    check_status("abort");
    access(1'b0, 32'(BASE + 1), '0, 0);

    // Fill the whole window, including both data extremes, then read back.
    for (int i = 0; i < DEPTH; i++) begin
      d = (i == 0) ? 32'h0 : (i == DEPTH - 1) ? 32'hFFFFFFFF : $urandom;
      access(1'b1, 32'(BASE + i), d, 0);
    end
    for (int i = 0; i < DEPTH; i++) access(1'b0, 32'(BASE + i), '0, 0);
    check_status("fill");

    access(1'b1, 32'(BASE + 2), 32'hA5A5A5A5, 0);
    access(1'b0, 32'(BASE + 2), '0, 0);

    // Out-of-window traffic is acked, discarded and flags err_o.
    access(1'b1, 32'd40, 32'h12345678, 0);
    access(1'b0, 32'd40, '0, 0);
    access(1'b0, 32'd5, '0, 0);
    check_status("oor");
    for (int i = 0; i < DEPTH; i++) access(1'b0, 32'(BASE + i), '0, 0);

    access(1'b1, 32'(BASE + 4), $urandom, 4);
    check_status("held");

    for (int n = 0; n < 40; n++) begin
      access(1'($urandom_range(0, 1)), 32'($urandom_range(8, 40)), $urandom,
             int'($urandom_range(0, 3)));
    end
    check_status("random");

    // Reset during WAIT clears everything asynchronously.
    $display("txn RESET_IN_WAIT adr=%h", 32'(BASE + 2));
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 32'(BASE + 2); bus.dat_i = 32'h5A5A5A5A;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("wait_rst_ack", 32'(bus.ack_o), 32'd0);
    check("wait_rst_dat", bus.dat_o, 32'd0);
    check_status("wait_rst");
    @(negedge clk) drop_req();
    @(negedge clk) rst = 1'b1;
    access(1'b0, 32'(BASE + 2), '0, 0);
    access(1'b1, 32'(BASE + 2), 32'hC3C3C3C3, 0);
    access(1'b0, 32'(BASE + 2), '0, 0);

    // Reset while ack_o is high must drop it without waiting for a clock.
    $display("txn RESET_IN_ACK adr=%h", 32'(BASE + 3));
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 32'(BASE + 3); bus.dat_i = 32'h77777777;
    @(posedge clk);
    repeat (WS) @(posedge clk);
    #1 check("ack_before_rst", 32'(bus.ack_o), 32'd1);
    #1 rst = 1'b0;
    model_reset();
    #1 check("ack_async_drop", 32'(bus.ack_o), 32'd0);
    @(negedge clk) drop_req();
    @(negedge clk) rst = 1'b1;
    access(1'b0, 32'(BASE + 3), '0, 0);
    access(1'b0, 32'(BASE + 2), '0, 0);
    check_status("final");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
